load_unit: RTL and testbench
============================

Name: load_unit

Overview:
- Read-side sequencer that fetches load data from data memory over a req/ack handshake.
- Presents the returned byte, plus a one-cycle completion strobe, to the writeback select path.
- Sits between the control unit (load request, stall) and data memory; LoadData feeds the write-back mux memory-data input, and LoadDone drives that mux's Load select and the register-file write enable.
- Adds a bounded wait with a sticky timeout error.

Parameters:
- ADDR_W, 8, width of load address and MemAddr.
- DATA_W, 8, width of MemData and LoadData.
- TIMEOUT, 15, maximum REQ cycles to wait for MemAck (legal range 1..255).

Ports:
- CLK  input  1  system clock, rising edge; the single clock of the block.
- Reset_n  input  1  reset; one clock, asynchronous assert, active-low.
- Start  input  1  load request from control; sampled on the CLK rising edge.
- Addr  input  ADDR_W  load address, valid with Start.
- MemReq  output  1  memory read request, held until ack or timeout.
- MemAddr  output  ADDR_W  registered read address, stable while MemReq=1.
- MemAck  input  1  memory has MemData valid this cycle.
- MemData  input  DATA_W  read data, sampled only when MemReq=1 and MemAck=1.
- LoadData  output  DATA_W  captured load byte, held until the next completion.
- LoadDone  output  1  one-cycle strobe: LoadData is valid and must be written back.
- Stall  output  1  freezes PC/pipeline while a load is outstanding.
- Error  output  1  sticky timeout flag.
- ErrClr  input  1  synchronous clear of Error.

Behaviour:
- Reset values (Reset_n=0, async): state IDLE, MemReq=0, MemAddr=0, LoadData=0, LoadDone=0, Error=0, wait counter=0. Reset mid-REQ drops MemReq immediately and aborts the load with no LoadDone.
- States and transitions:
  - IDLE: Start=1 at edge → latch Addr into MemAddr, counter=0, go REQ.
  - REQ: MemReq=1.
    - MemAck=1 at edge → LoadData<=MemData, go DONE.
    - Otherwise, if counter==TIMEOUT-1 → LoadData<=0, Error<=1, go DONE.
    - Otherwise counter<=counter+1.
  - DONE: LoadDone=1 for exactly this cycle.
    - Start=1 at edge → latch Addr, go REQ (back-to-back load, no idle gap).
    - Otherwise go IDLE.
- Output decode:
  - MemReq = (state==REQ), registered-state decode with no combinational path from inputs.
  - LoadDone = (state==DONE).
  - Stall = (state==REQ) | (Start & state!=REQ). Combinational, so the request cycle itself stalls; deasserts in the DONE cycle.
- Latency: Start at edge E0, MemAck high in the first REQ cycle → LoadDone high after E1. Minimum 2 edges Start→LoadDone; each ack wait cycle adds 1.
- Timeout: MemReq is high for exactly TIMEOUT cycles when no ack arrives. MemAck on the final REQ cycle wins over timeout (data captured, Error unchanged).
- Start while in REQ: ignored (controller is stalled); no queuing.
- MemAck outside REQ: ignored; LoadData unchanged.
- Error: set on timeout, cleared by ErrClr=1 at an edge. Simultaneous set and clear: set wins. Error does not block further loads.
- LoadData changes only on the transition into DONE; stable in all other cycles.
- Counter width is ceil(log2(TIMEOUT+1)); it never wraps because it is bounded by TIMEOUT-1.

Test Plan:
- Reset: drive Reset_n=0 mid-REQ with MemReq=1 → MemReq, LoadDone, Stall(Start=0), Error, LoadData all 0 before the next edge; no LoadDone after release.
- Zero-wait load: Start=1, Addr=8'h3C; memory acks the first REQ cycle with 8'hA5 → MemAddr=8'h3C, MemReq high 1 cycle, LoadData=8'hA5, LoadDone high exactly 1 cycle 2 edges after Start, Stall high 2 cycles.
- Wait states: Addr=8'h10, ack after 4 REQ cycles with 8'h5A → MemReq high 4 cycles with MemAddr stable, Stall high 5 cycles, LoadData=8'h5A, Error=0.
- Timeout: TIMEOUT=15, no ack → MemReq high exactly 15 cycles, then LoadDone=1, LoadData=8'h00, Error=1; Error persists through a following good load (8'h77 loads correctly); ErrClr=1 for one edge → Error=0.
- Boundary: ack on the 15th REQ cycle with 8'hC3 → LoadData=8'hC3, Error stays 0. Separately, ErrClr=1 in the same cycle a timeout occurs → Error=1.
- Back-to-back: Start held in the DONE cycle with Addr=8'h21 after a load of 8'h20 → MemReq reasserts the cycle after LoadDone with MemAddr=8'h21. Start pulsed during REQ is ignored (only one LoadDone per accepted request).

Source files
------------

// File: rtl/load_unit.sv
// load_unit: read-side load sequencer. Issues a req/ack read to data memory,
// captures the returned data, strobes LoadDone for one cycle and flags a
// sticky Error when memory fails to acknowledge within TIMEOUT request cycles.
module load_unit #(
   parameter int ADDR_W  = 8,
   parameter int DATA_W  = 8,
   parameter int TIMEOUT = 15
) (
   input  logic              CLK,
   input  logic              Reset_n,
   input  logic              Start,
   input  logic [ADDR_W-1:0] Addr,
   output logic              MemReq,
   output logic [ADDR_W-1:0] MemAddr,
   input  logic              MemAck,
   input  logic [DATA_W-1:0] MemData,
   output logic [DATA_W-1:0] LoadData,
   output logic              LoadDone,
   output logic              Stall,
   output logic              Error,
   input  logic              ErrClr
);

   // Counter only has to reach TIMEOUT-1, so it can never wrap.
   localparam int               CNT_W    = $clog2(TIMEOUT + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(TIMEOUT - 1);

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_REQ  = 2'd1,
      ST_DONE = 2'd2
   } state_t;

   state_t            state_q, state_d;
   logic [ADDR_W-1:0] addr_q,  addr_d;
   logic [DATA_W-1:0] data_q,  data_d;
   logic [CNT_W-1:0]  cnt_q,   cnt_d;
   logic              err_q,   err_d;

   // State and datapath registers; reset aborts any outstanding load at once.
   always_ff @(posedge CLK or negedge Reset_n) begin
      if (!Reset_n) begin
         state_q <= ST_IDLE;
         addr_q  <= '0;
         data_q  <= '0;
         cnt_q   <= '0;
         err_q   <= 1'b0;
      end else begin
         state_q <= state_d;
         addr_q  <= addr_d;
         data_q  <= data_d;
         cnt_q   <= cnt_d;
         err_q   <= err_d;
      end
   end

   // Next-state and datapath update; timeout set is applied after clear so set wins.
   always_comb begin
      state_d = state_q;
      addr_d  = addr_q;
      data_d  = data_q;
      cnt_d   = cnt_q;
      err_d   = err_q;
      if (ErrClr) begin
         err_d = 1'b0;
      end
      case (state_q)
         ST_IDLE: begin
            if (Start) begin
               addr_d  = Addr;
               cnt_d   = '0;
               state_d = ST_REQ;
            end
         end
         ST_REQ: begin
            // An ack on the last allowed cycle still beats the timeout.
            if (MemAck) begin
               data_d  = MemData;
               state_d = ST_DONE;
            end else if (cnt_q == CNT_LAST) begin
               data_d  = '0;
               err_d   = 1'b1;
               state_d = ST_DONE;
            end else begin
               cnt_d = cnt_q + CNT_W'(1);
            end
         end
         ST_DONE: begin
            // Back-to-back load: go straight to REQ without an idle gap.
            if (Start) begin
               addr_d  = Addr;
               cnt_d   = '0;
               state_d = ST_REQ;
            end else begin
               state_d = ST_IDLE;
            end
         end
         default: begin
            state_d = ST_IDLE;
         end
      endcase
   end

   // Output decode; only Stall looks at an input so the request cycle itself stalls.
   always_comb begin
      MemReq   = (state_q == ST_REQ);
      LoadDone = (state_q == ST_DONE);
      Stall    = (state_q == ST_REQ) | (Start & (state_q != ST_REQ));
      MemAddr  = addr_q;
      LoadData = data_q;
      Error    = err_q;
   end

endmodule

// File: tb/tb_load_unit.sv
// tb_load_unit: directed stimulus with a scoreboard; the monitor pops an
// expected {LoadData, Error} pair on every LoadDone strobe.
module tb_load_unit;

   localparam int TMO = 15;

   logic       clk = 1'b0;
   logic       Reset_n;
   logic       Start;
   logic [7:0] Addr;
   logic       MemReq;
   logic [7:0] MemAddr;
   logic       MemAck;
   logic [7:0] MemData;
   logic [7:0] LoadData;
   logic       LoadDone;
   logic       Stall;
   logic       Error;
   logic       ErrClr;

   int n_checks = 0;
   int n_fail   = 0;

   logic [8:0] sb_q[$];

   load_unit #(.ADDR_W(8), .DATA_W(8), .TIMEOUT(TMO)) dut (
      .CLK      (clk),
      .Reset_n  (Reset_n),
      .Start    (Start),
      .Addr     (Addr),
      .MemReq   (MemReq),
      .MemAddr  (MemAddr),
      .MemAck   (MemAck),
      .MemData  (MemData),
      .LoadData (LoadData),
      .LoadDone (LoadDone),
      .Stall    (Stall),
      .Error    (Error),
      .ErrClr   (ErrClr)
   );

   always #5 clk = ~clk;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", name, act, exp);
      end else begin
         $display("ok   %s: %0h", name, act);
      end
   endtask

   // Monitor: every completion must match the oldest outstanding expectation.
   always @(negedge clk) begin
      if (Reset_n && LoadDone) begin
         n_checks++;
         if (sb_q.size() == 0) begin
            n_fail++;
            $display("FAIL unexpected_done: got LoadData=%0h Error=%0b expected no completion", LoadData, Error);
         end else begin
            logic [8:0] exp;
            exp = sb_q.pop_front();
            if ({LoadData, Error} !== exp) begin
               n_fail++;
               $display("FAIL done_data: got LoadData=%0h Error=%0b expected LoadData=%0h Error=%0b",
                        LoadData, Error, exp[8:1], exp[0]);
            end else begin
               $display("done LoadData=%0h Error=%0b", LoadData, Error);
            end
         end
      end
   end

   // One load: memory acks on REQ cycle ack_at (0 = never); optional Start
   // pulse and ErrClr on given REQ cycles; optional chained Start in DONE.
   task automatic do_load(input string name, input logic [7:0] a, input logic [7:0] d,
                          input int ack_at, input int pulse_at, input int clr_at,
                          input int exp_req, input int exp_stall, input logic exp_err,
                          input bit skip_start, input bit chain, input logic [7:0] chain_addr);
      int   reqc;
      int   stallc;
      bit   addr_ok;
      bit   done_seen;
      logic [7:0] ed;
      ed = (ack_at > 0 && ack_at <= TMO) ? d : 8'h00;
      sb_q.push_back({ed, exp_err});
      reqc = 0; stallc = 0; addr_ok = 1; done_seen = 0;
      if (!skip_start) begin
         @(negedge clk);
         Start = 1'b1;
         Addr  = a;
         #1 if (Stall) stallc++;
      end
      for (int cyc = 0; cyc < 40; cyc++) begin
         @(negedge clk);
         Start  = 1'b0;
         MemAck = 1'b0;
         ErrClr = 1'b0;
         #1;
         if (!MemReq) begin
            done_seen = 1;
            break;
         end
         reqc++;
         if (Stall) stallc++;
         if (MemAddr !== a) addr_ok = 0;
         if (reqc == ack_at) begin
            MemAck  = 1'b1;
            MemData = d;
         end else begin
            MemData = 8'hFF;
         end
         if (reqc == pulse_at) begin
            Start = 1'b1;
            Addr  = 8'hEE;
         end
         if (reqc == clr_at) ErrClr = 1'b1;
      end
      check({name, "_bounded"}, 32'(done_seen), 32'd1);
      check({name, "_done_strobe"}, 32'(LoadDone), 32'd1);
      check({name, "_req_cycles"}, reqc, exp_req);
      check({name, "_stall_cycles"}, stallc, exp_stall);
      check({name, "_addr_stable"}, 32'(addr_ok), 32'd1);
      if (chain) begin
         Start = 1'b1;
         Addr  = chain_addr;
      end
   endtask

   initial begin
      Reset_n = 1'b0; Start = 1'b0; Addr = 8'h00; MemAck = 1'b0;
      MemData = 8'h00; ErrClr = 1'b0;
      #1;
      check("rst_memreq",   32'(MemReq),   32'd0);
      check("rst_loaddone", 32'(LoadDone), 32'd0);
      check("rst_loaddata", 32'(LoadData), 32'd0);
      check("rst_error",    32'(Error),    32'd0);
      check("rst_memaddr",  32'(MemAddr),  32'd0);
      check("rst_stall",    32'(Stall),    32'd0);
      @(negedge clk); @(negedge clk);
      Reset_n = 1'b1;
      @(negedge clk);

      //       name        addr   data   ack pls clr req stl err  skip chain caddr
      do_load("zero_wait", 8'h3C, 8'hA5,  1,  0,  0,  1,  2, 1'b0, 0, 0, 8'h00);
      do_load("wait4",     8'h10, 8'h5A,  4,  2,  0,  4,  5, 1'b0, 0, 0, 8'h00);
      do_load("timeout",   8'h01, 8'h00,  0,  0,  0, 15, 16, 1'b1, 0, 0, 8'h00);
      do_load("after_tmo", 8'h44, 8'h77,  1,  0,  0,  1,  2, 1'b1, 0, 0, 8'h00);

      @(negedge clk);
      ErrClr = 1'b1;
      @(negedge clk);
      ErrClr = 1'b0;
      #1 check("errclr", 32'(Error), 32'd0);

      do_load("ack_last",  8'h55, 8'hC3, 15,  0,  0, 15, 16, 1'b0, 0, 0, 8'h00);
      do_load("clr_vs_set",8'h66, 8'h00,  0,  0, 15, 15, 16, 1'b1, 0, 0, 8'h00);
      do_load("b2b_first", 8'h20, 8'h99,  1,  0,  0,  1,  2, 1'b1, 0, 1, 8'h21);
      do_load("b2b_second",8'h21, 8'hB7,  2,  0,  0,  2,  2, 1'b1, 1, 0, 8'h00);

      // Reset in the middle of a request with Error set and LoadData nonzero.
      @(negedge clk);
      Start = 1'b1; Addr = 8'h77;
      @(negedge clk);
      Start = 1'b0;
      #1 check("pre_rst_memreq", 32'(MemReq), 32'd1);
      #2 Reset_n = 1'b0;
      #1;
      check("midrst_memreq",   32'(MemReq),   32'd0);
      check("midrst_loaddone", 32'(LoadDone), 32'd0);
      check("midrst_stall",    32'(Stall),    32'd0);
      check("midrst_error",    32'(Error),    32'd0);
      check("midrst_loaddata", 32'(LoadData), 32'd0);
      @(negedge clk);
      Reset_n = 1'b1;
      for (int i = 0; i < 5; i++) begin
         @(negedge clk);
         #1 check("post_rst_idle", 32'({LoadDone, MemReq}), 32'd0);
      end

      check("scoreboard_empty", 32'(sb_q.size()), 32'd0);
      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
